// File: rtl/shift_reg_sequencer_if.sv
// shift_reg_sequencer_if: command handshake and status bundle for the shift register sequencer
//  master drives cmd_valid/cmd_op/cmd_load/cmd_data/cmd_amt/abort and observes cmd_ready/busy/done/err/result
//  slave is the sequencer side
interface shift_reg_sequencer_if #(
  parameter int N  = 4,
  parameter int AW = $clog2(N) + 1
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic          cmd_load;
  logic [N-1:0]  cmd_data;
  logic [AW-1:0] cmd_amt;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic [N-1:0]  result;
  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_data, cmd_amt, abort,
    input  cmd_ready, busy, done, err, result
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_data, cmd_amt, abort,
    output cmd_ready, busy, done, err, result
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: sequences a 4-mode universal shift register through load + multi-bit shifts/rotates
//  CLK/Clear: clock and async active-low reset (shared with the register)
//  cmd: command handshake, abort and done/err/result status
//  sr_s/sr_value/sr_msb/sr_lsb: register mode, parallel input and serial-in bits; sr_q: register output
module shift_reg_sequencer #(
  parameter int N  = 4,
  parameter int AW = $clog2(N) + 1
) (
  input  logic                   CLK,
  input  logic                   Clear,
  shift_reg_sequencer_if.slave   cmd,
  output logic [1:0]             sr_s,
  output logic [N-1:0]           sr_value,
  output logic                   sr_msb,
  output logic                   sr_lsb,
  input  logic [N-1:0]           sr_q
);
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_ASR  = 3'd3;
  localparam logic [2:0] OP_ROTL = 3'd4;
  localparam logic [2:0] OP_ROTR = 3'd5;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t        state, state_n;
  logic [AW-1:0] count, count_n, amt_q;
  logic [2:0]    op_q;
  logic [N-1:0]  data_q;
  logic          err_q;
  logic          accept, illegal, go_shift, shift_left;
  assign accept     = state == IDLE && cmd.cmd_valid;
  assign illegal    = cmd.cmd_op[2:1] == 2'b11;
  assign go_shift   = amt_q != '0 && op_q != OP_NOP;
  assign shift_left = op_q == OP_SHL || op_q == OP_ROTL;
  assign cmd.cmd_ready = state == IDLE;
  assign cmd.busy      = state != IDLE;
  assign cmd.done      = state == DONE;
  assign cmd.err       = state == DONE && err_q;
  assign cmd.result    = sr_q;
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state  <= IDLE;
      count  <= '0;
      op_q   <= '0;
      data_q <= '0;
      amt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (accept) begin
        op_q   <= cmd.cmd_op;
        data_q <= cmd.cmd_data;
        amt_q  <= cmd.cmd_amt;
        err_q  <= illegal;
      end
    end
  end
  always_comb begin
    state_n  = state;
    count_n  = count;
    sr_s     = 2'b00;
    sr_value = '0;
    sr_msb   = 1'b0;
    sr_lsb   = 1'b0;
    case (state)
      IDLE: begin
        count_n = cmd.cmd_amt;
        // an illegal op skips both load and shift, even when cmd_load is set
        if (cmd.cmd_valid)
          state_n = illegal ? DONE : cmd.cmd_load ? LOAD :
                    (cmd.cmd_amt == '0 || cmd.cmd_op == OP_NOP) ? DONE : SHIFT;
      end
      LOAD: begin
        sr_value = data_q;
        sr_s     = cmd.abort ? 2'b00 : 2'b11;
        count_n  = amt_q;
        state_n  = cmd.abort ? IDLE : go_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        // serial-in bits follow the live register output so rotates and sign-fill track each step
        sr_s    = cmd.abort ? 2'b00 : shift_left ? 2'b10 : 2'b01;
        sr_msb  = op_q == OP_ASR ? sr_q[N-1] : op_q == OP_ROTR ? sr_q[0] : 1'b0;
        sr_lsb  = op_q == OP_ROTL ? sr_q[N-1] : 1'b0;
        count_n = count - AW'(1);
        state_n = cmd.abort ? IDLE : count == AW'(1) ? DONE : SHIFT;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: drives the sequencer plus a universal shift register and checks against a step model
module tb_shift_reg_sequencer;
  logic       CLK = 1'b0;
  logic       Clear = 1'b0;
  logic [1:0] sr_s;
  logic [3:0] sr_value;
  logic       sr_msb, sr_lsb;
  logic [3:0] q;
  int         chk = 0;
  int         errs = 0;
  logic [1:0] s_log[$];
  logic [3:0] q_log[$];
  int         dcyc;
  logic [3:0] res;
  logic       e;
  logic       rdy_bad;
  shift_reg_sequencer_if #(.N(4), .AW(3)) bus ();
  shift_reg_sequencer #(.N(4), .AW(3)) dut (
    .CLK(CLK), .Clear(Clear), .cmd(bus.slave),
    .sr_s(sr_s), .sr_value(sr_value), .sr_msb(sr_msb), .sr_lsb(sr_lsb), .sr_q(q)
  );
  always #5 CLK = ~CLK;
  always_ff @(posedge CLK or negedge Clear)
    if (!Clear) q <= 4'b0;
    else if (sr_s == 2'b01) q <= {sr_msb, q[3:1]};
    else if (sr_s == 2'b10) q <= {q[2:0], sr_lsb};
    else if (sr_s == 2'b11) q <= sr_value;
  function automatic int model(input int v, input int op, input int amt);
    for (int i = 0; i < amt; i++)
      case (op)
        1: v = (v * 2) % 16;
        2: v = v / 2;
        3: v = v / 2 + (v >= 8 ? 8 : 0);
        4: v = (v * 2) % 16 + v / 8;
        5: v = v / 2 + (v % 2) * 8;
        default: v = v;
      endcase
    return v;
  endfunction
  function automatic int model_cyc(input int ld, input int op, input int amt);
    if (op >= 6) return 1;
    return ld + (op == 0 ? 0 : amt) + 1;
  endfunction
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic run_cmd(input logic ld, input logic [3:0] d, input logic [2:0] op, input logic [2:0] amt);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_data  = d;
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    step();
    bus.cmd_valid = 1'b0;
    s_log.delete();
    q_log.delete();
    dcyc = -1;
    res = 'x;
    e = 1'b0;
    rdy_bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      s_log.push_back(sr_s);
      q_log.push_back(q);
      if (bus.cmd_ready !== 1'b0) rdy_bad = 1'b1;
      if (bus.done === 1'b1) begin
        dcyc = k;
        res = bus.result;
        e = bus.err;
        step();
        break;
      end
      step();
    end
  endtask
  task automatic test_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd1;
    bus.cmd_load = 1'b1;
    bus.cmd_data = 4'hF;
    bus.cmd_amt = 3'd2;
    bus.abort = 1'b0;
    repeat (3) step();
    chk++;
    if ({bus.busy, bus.done, bus.err, sr_s, sr_value, sr_msb, sr_lsb, q} !== 13'b0) begin
      errs++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b s=%b v=%b msb=%b lsb=%b q=%b want all 0",
               bus.busy, bus.done, bus.err, sr_s, sr_value, sr_msb, sr_lsb, q);
    end
    chk++;
    if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
    bus.cmd_valid = 1'b0;
    #2 Clear = 1'b1;
    step();
    chk++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_release_busy got %b want 0", bus.busy); end
  endtask
  task automatic test_directed();
    run_cmd(1'b1, 4'b1011, 3'd1, 3'd1);
    chk++;
    if (dcyc != 3 || res !== 4'b0110 || e !== 1'b0) begin
      errs++; $display("FAIL shl1 got cyc=%0d res=%b err=%b want cyc=3 res=0110 err=0", dcyc, res, e);
    end
    chk++;
    if (s_log.size() < 3 || s_log[0] !== 2'b11 || s_log[1] !== 2'b10 || s_log[2] !== 2'b00) begin
      errs++; $display("FAIL shl1_modes got %p want 11,10,00", s_log);
    end
    chk++;
    if (rdy_bad) begin errs++; $display("FAIL shl1_ready got ready=1 while busy want 0"); end
    run_cmd(1'b1, 4'b1001, 3'd5, 3'd3);
    chk++;
    if (dcyc != 5 || res !== 4'b0011) begin
      errs++; $display("FAIL rotr3 got cyc=%0d res=%b want cyc=5 res=0011", dcyc, res);
    end
    chk++;
    if (q_log.size() < 5 || q_log[1] !== 4'b1001 || q_log[2] !== 4'b1100 || q_log[3] !== 4'b0110 || q_log[4] !== 4'b0011) begin
      errs++; $display("FAIL rotr3_seq got %p want q 1001,1100,0110,0011 in cycles 2..5", q_log);
    end
    run_cmd(1'b1, 4'b1000, 3'd3, 3'd2);
    chk++;
    if (dcyc != 4 || res !== 4'b1110 || q_log[2] !== 4'b1100) begin
      errs++; $display("FAIL asr2 got cyc=%0d res=%b mid=%b want cyc=4 res=1110 mid=1100", dcyc, res, q_log[2]);
    end
    run_cmd(1'b0, 4'b1111, 3'd2, 3'd5);
    chk++;
    if (dcyc != 6 || res !== 4'b0000) begin
      errs++; $display("FAIL shr5 got cyc=%0d res=%b want cyc=6 res=0000", dcyc, res);
    end
    run_cmd(1'b1, 4'b0101, 3'd1, 3'd0);
    chk++;
    if (dcyc != 2 || res !== 4'b0101 || s_log.size() < 2 || s_log[0] !== 2'b11 || s_log[1] !== 2'b00) begin
      errs++; $display("FAIL shl0 got cyc=%0d res=%b modes=%p want cyc=2 res=0101 modes 11,00", dcyc, res, s_log);
    end
    run_cmd(1'b1, 4'b1111, 3'd6, 3'd3);
    chk++;
    if (dcyc != 1 || e !== 1'b1 || res !== 4'b0101 || q !== 4'b0101 || s_log[0] !== 2'b00) begin
      errs++; $display("FAIL illegal got cyc=%0d err=%b res=%b q=%b s=%b want cyc=1 err=1 res=0101 q=0101 s=00",
                       dcyc, e, res, q, s_log[0]);
    end
  endtask
  task automatic test_abort();
    logic saw_done;
    logic [1:0] s_abort;
    saw_done = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_load = 1'b1; bus.cmd_data = 4'b0011; bus.cmd_op = 3'd4; bus.cmd_amt = 3'd6;
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      saw_done |= bus.done;
      step();
    end
    bus.abort = 1'b1;
    #1 s_abort = sr_s;
    saw_done |= bus.done;
    step();
    bus.abort = 1'b0;
    saw_done |= bus.done;
    chk++;
    if (s_abort !== 2'b00) begin errs++; $display("FAIL abort_mode got %b want 00", s_abort); end
    chk++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || saw_done) begin
      errs++; $display("FAIL abort_idle got busy=%b ready=%b done_seen=%b want 0,1,0", bus.busy, bus.cmd_ready, saw_done);
    end
    chk++;
    if (q !== 4'b1100) begin errs++; $display("FAIL abort_q got %b want 1100", q); end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    run_cmd(1'b1, 4'b0110, 3'd4, 3'd6);
    chk++;
    if (dcyc != 8 || res !== 4'b1001) begin
      errs++; $display("FAIL rotl6 got cyc=%0d res=%b want cyc=8 res=1001", dcyc, res);
    end
  endtask
  task automatic test_clear();
    bus.cmd_valid = 1'b1; bus.cmd_load = 1'b1; bus.cmd_data = 4'b0011; bus.cmd_op = 3'd4; bus.cmd_amt = 3'd6;
    step();
    bus.cmd_valid = 1'b0;
    repeat (3) step();
    Clear = 1'b0;
    #1;
    chk++;
    if ({bus.busy, bus.done, bus.err, sr_s, sr_value, sr_msb, sr_lsb, q} !== 13'b0 || bus.cmd_ready !== 1'b1) begin
      errs++; $display("FAIL clear_mid got busy=%b done=%b s=%b v=%b q=%b ready=%b want 0s and ready=1",
                       bus.busy, bus.done, sr_s, sr_value, q, bus.cmd_ready);
    end
    #1 Clear = 1'b1;
    step();
    run_cmd(1'b1, 4'b1010, 3'd2, 3'd1);
    chk++;
    if (dcyc != 3 || res !== 4'b0101) begin
      errs++; $display("FAIL clear_recover got cyc=%0d res=%b want cyc=3 res=0101", dcyc, res);
    end
  endtask
  task automatic test_random();
    int mq, ld, d, op, amt, want;
    mq = q;
    for (int i = 0; i < 40; i++) begin
      ld  = (i == 0) ? 1 : int'($urandom_range(0, 1));
      d   = int'($urandom_range(0, 15));
      op  = int'($urandom_range(0, 7));
      amt = int'($urandom_range(0, 7));
      want = (op >= 6) ? mq : model(ld ? d : mq, op, amt);
      run_cmd(ld[0], d[3:0], op[2:0], amt[2:0]);
      chk++;
      if (dcyc != model_cyc(ld, op, amt) || res !== want[3:0] || e !== (op >= 6)) begin
        errs++;
        $display("FAIL rand%0d ld=%0d d=%0d op=%0d amt=%0d got cyc=%0d res=%0d err=%b want cyc=%0d res=%0d err=%b",
                 i, ld, d, op, amt, dcyc, res, e, model_cyc(ld, op, amt), want, op >= 6);
      end
      mq = want;
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_load = 1'b0;
    bus.cmd_data = 4'd0;
    bus.cmd_amt = 3'd0;
    bus.abort = 1'b0;
    test_reset();
    test_directed();
    test_abort();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
